lfsr_encrypt5: RTL and testbench
================================

# lfsr_encrypt5

Upstream encryption stage for the lab 5 decryption block. Reads a plaintext message from its internal data memory at addresses 0..63 and prepends a run of ASCII `_` (0x5F) preamble characters. Encrypts the stream with one of the six maximal-length 6-bit LFSR patterns and writes 64 ciphertext bytes to addresses 64..127. This is the memory image the decryption stage consumes.

## Interface
Parameters:
- MSG_LEN, 64: ciphertext bytes produced.
- ENC_BASE, 64: first ciphertext address.

Ports:
- clk, input, 1: the single clock.
- init, input, 1: reset, synchronous and active-high. While high the block is held in reset; operation starts on the first clk edge with init low.
- pat_sel, input, 3: LFSR pattern index 0..5. Values 6 and 7 map to 0.
- seed, input, 6: LFSR start state. 6'h00 is replaced by 6'h01.
- pre_len, input, 8: preamble length, clamped to 7..12.
- done, output, 1: high once all ciphertext is written. Holds until init.

## Operation
Pattern table, indexed by pat_sel: 0 = 6'h21, 1 = 6'h2D, 2 = 6'h30, 3 = 6'h33, 4 = 6'h36, 5 = 6'h39.

LFSR:
- s0 = seed, after the zero substitution.
- s(k+1) = {s(k)[4:0], ^(s(k) & taps)}.

Plain stream p(k), k = 0..63:
- p(k) = 8'h5F for k < PL, where PL is the clamped pre_len.
- Otherwise p(k) = mem[k-PL].

Ciphertext: mem[ENC_BASE+k] = p(k) ^ {2'b00, s(k)}. Bits 7:6 pass through unchanged.

FSM states:
- RESET: entered whenever init is high. done=0; counter k=0; output of every block register is 0.
- LOAD: one cycle. Latches pat_sel, seed and pre_len after mapping, substitution and clamping. Loads the LFSR with s0. No memory write.
- RUN: 64 cycles, k = 0..63.
  - raddr = k-PL (8-bit) when k >= PL; otherwise the read is don't-care.
  - write_en=1, waddr = ENC_BASE+k, data_in as above.
  - The LFSR advances at the end of each cycle.
  - Leaves to FIN when k == 63.
- FIN: done=1, write_en=0. Stays in FIN until init.

Boundary rules:
- Inputs are sampled only in LOAD. Changes during RUN are ignored.
- init high in any state forces RESET at the next edge. Memory contents are retained, so a partial ciphertext may remain until rerun.
- Plaintext addresses never exceed 63-PL, so reads never overlap the ciphertext region.
- k is 7 bits. Its terminal value is 63 and it never wraps.

## Timing
- Cycle 0 is the first edge with init low: LOAD.
- Cycles 1..64: RUN, writing ciphertext byte k = cycle-1.
- From cycle 65: done=1. Total latency is 65 cycles from init low.
- Memory read is combinational (data_out = mem[raddr] in the same cycle). Memory write is synchronous on clk.
- The write of byte k is visible at the edge ending cycle k+1.

## Structure
- Shared package lab5_pkg holds:
  - the LFSR_ptrn[6] constant array;
  - PAD_CHAR = 8'h5F;
  - ENC_BASE;
  - MSG_LEN;
  - PRE_MIN = 7, PRE_MAX = 12;
  - the FSM state enum {RESET, LOAD, RUN, FIN}.
- Reused sub-modules:
  - dat_mem (256x8, ports clk, write_en, raddr, waddr, data_in, data_out).
  - lfsr6 (ports clk, en, init, taps, start, state): one instance, init driven in LOAD, en driven in RUN.

## Test plan
- Preamble stream: pat_sel=0, seed=6'h01, pre_len=7, mem[0]=8'h48 -> mem[64..71] = 5E, 5C, 58, 50, 40, 60, 61, 75. Done rises at cycle 65.
- Zero seed: seed=6'h00, otherwise as above -> output identical to the seed=6'h01 case.
- Clamping: pre_len=3 -> mem[64..70] all carry the padding pattern and mem[71] encrypts mem[0]. pre_len=200 -> PL=12.
- Index mapping: pat_sel=7 -> identical to pat_sel=0.
- Reset mid-run: init high at cycle 30 for 2 cycles, then low with new seed -> done stays low, the full run restarts, and the final image matches a clean run with the new seed.
- Round trip: for each pat_sel 0..5 with random seed, pre_len and printable message, feed the memory image to the decryption stage -> recovered mem[0..] equals the original plaintext.

Source files
------------

// File: rtl/lab5_pkg.sv
// Shared constants, FSM state type and small input-conditioning helpers for
// the lab 5 LFSR encryption stage.
package lab5_pkg;

  localparam int MSG_LEN  = 64;
  localparam int ENC_BASE = 64;

  localparam logic [7:0] PAD_CHAR = 8'h5F;
  localparam logic [7:0] PRE_MIN  = 8'd7;
  localparam logic [7:0] PRE_MAX  = 8'd12;

  // The six maximal-length tap patterns for a 6-bit LFSR.
  localparam logic [5:0] LFSR_ptrn [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  typedef enum logic [1:0] {
    RESET = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Out-of-range pattern indices fall back to pattern 0.
  function automatic logic [5:0] taps_for(input logic [2:0] sel);
    logic [2:0] idx;
    idx = (sel > 3'd5) ? 3'd0 : sel;
    return LFSR_ptrn[idx];
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [5:0] fix_seed(input logic [5:0] s);
    return (s == 6'h00) ? 6'h01 : s;
  endfunction

  function automatic logic [7:0] clamp_pre(input logic [7:0] len);
    if (len < PRE_MIN) return PRE_MIN;
    if (len > PRE_MAX) return PRE_MAX;
    return len;
  endfunction

endpackage

// File: rtl/dat_mem.sv
// 256x8 data memory: combinational read, synchronous write. No reset, so
// contents survive a block reset.
module dat_mem (
  input  logic       clk,
  input  logic       write_en,
  input  logic [7:0] raddr,
  input  logic [7:0] waddr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    if (write_en) mem[waddr] <= data_in;
  end

  assign data_out = mem[raddr];

endmodule

// File: rtl/lfsr6.sv
// 6-bit Fibonacci-style LFSR: shift left, feedback is the parity of the
// tapped bits. init loads start and takes priority over en.
module lfsr6 (
  input  logic       clk,
  input  logic       en,
  input  logic       init,
  input  logic [5:0] taps,
  input  logic [5:0] start,
  output logic [5:0] state
);

  always_ff @(posedge clk) begin
    if (init) begin
      state <= start;
    end else if (en) begin
      state <= {state[4:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_encrypt5.sv
// Encrypts a preamble-padded message from mem[0..] into mem[ENC_BASE..]
// using one of six 6-bit LFSR keystreams.
module lfsr_encrypt5
  import lab5_pkg::*;
#(
  parameter int MSG_LEN  = lab5_pkg::MSG_LEN,
  parameter int ENC_BASE = lab5_pkg::ENC_BASE
) (
  input  logic       clk,
  input  logic       init,
  input  logic [2:0] pat_sel,
  input  logic [5:0] seed,
  input  logic [7:0] pre_len,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam logic [6:0] K_LAST = 7'(MSG_LEN - 1);
  localparam logic [7:0] BASE8  = 8'(ENC_BASE);

  // Handshake-free block: init is the only control input; done is a level
  // that stays high from the last write until init is raised again.

  state_t     state, state_nxt;
  logic [6:0] k_q;
  logic [5:0] taps_q;
  logic [7:0] pl_q;

  logic       write_en;
  logic       lfsr_en;
  logic       lfsr_load;
  logic       lfsr_init;
  logic [5:0] lfsr_start;
  logic [5:0] lfsr_state;

  logic       in_pad;
  logic [7:0] raddr;
  logic [7:0] waddr;
  logic [7:0] rdata;
  logic [7:0] plain;
  logic [7:0] wdata;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (init) state <= RESET;
    else      state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      RESET:   state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     state_nxt = (k_q == K_LAST) ? FIN : RUN;
      FIN:     state_nxt = FIN;
      default: state_nxt = RESET;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    write_en  = 1'b0;
    lfsr_en   = 1'b0;
    lfsr_load = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD:    lfsr_load = 1'b1;
      RUN: begin
        write_en = 1'b1;
        lfsr_en  = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

  // ---- Configuration latch and byte counter ----
  always_ff @(posedge clk) begin
    if (init) begin
      k_q    <= '0;
      taps_q <= '0;
      pl_q   <= '0;
    end else begin
      if (state == LOAD) begin
        taps_q <= taps_for(pat_sel);
        pl_q   <= clamp_pre(pre_len);
        k_q    <= '0;
      end else if (state == RUN && k_q != K_LAST) begin
        k_q <= k_q + 7'd1;
      end
    end
  end

  // init also clears the LFSR so every block register reads 0 in RESET.
  assign lfsr_init  = init | lfsr_load;
  assign lfsr_start = init ? 6'h00 : fix_seed(seed);

  lfsr6 u_lfsr (
    .clk   (clk),
    .en    (lfsr_en),
    .init  (lfsr_init),
    .taps  (taps_q),
    .start (lfsr_start),
    .state (lfsr_state)
  );

  // ---- Datapath: plain byte selection and keystream XOR ----
  assign in_pad = ({1'b0, k_q} < pl_q);
  assign raddr  = in_pad ? 8'h00 : ({1'b0, k_q} - pl_q);
  assign plain  = in_pad ? PAD_CHAR : rdata;
  assign wdata  = plain ^ {2'b00, lfsr_state};
  assign waddr  = BASE8 + {1'b0, k_q};

  dat_mem u_mem (
    .clk      (clk),
    .write_en (write_en),
    .raddr    (raddr),
    .waddr    (waddr),
    .data_in  (wdata),
    .data_out (rdata)
  );

endmodule

// File: tb/tb_lfsr_encrypt5.sv
// Self-checking bench for lfsr_encrypt5: randomized runs compared against a
// sequence-level model of the preamble/keystream cipher.
module tb_lfsr_encrypt5;

  logic       clk;
  logic       init;
  logic [2:0] pat_sel;
  logic [5:0] seed;
  logic [7:0] pre_len;
  logic       done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] msg     [64];
  logic [7:0] ref_img [64];
  logic [5:0] tap_tab [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  lfsr_encrypt5 dut (
    .clk       (clk),
    .init      (init),
    .pat_sel   (pat_sel),
    .seed      (seed),
    .pre_len   (pre_len),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- checker ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int clamp_len(input logic [7:0] pl);
    if (pl < 8'd7)  return 7;
    if (pl > 8'd12) return 12;
    return int'(pl);
  endfunction

  function automatic logic [5:0] key_at(input logic [2:0] p, input logic [5:0] s, input int k);
    logic [5:0] t;
    logic [5:0] st;
    t  = tap_tab[(p > 3'd5) ? 0 : int'(p)];
    st = (s == 6'h00) ? 6'h01 : s;
    for (int i = 0; i < k; i++) st = {st[4:0], ^(st & t)};
    return st;
  endfunction

  function automatic void build_expected(input logic [2:0] p, input logic [5:0] s, input logic [7:0] pl);
    int         plc;
    logic [7:0] pb;
    plc = clamp_len(pl);
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      pb = (k < plc) ? 8'h5F : msg[k - plc];
      exp_q.push_back(pb ^ {2'b00, key_at(p, s, k)});
    end
  endfunction

  // ---- drivers ----
  task automatic load_msg();
    init = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.u_mem.mem[i] <= msg[i];
    @(negedge clk);
  endtask

  task automatic rand_msg();
    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(32, 126));
  endtask

  // Runs one encryption; abort_at >= 0 raises init at that cycle instead.
  task automatic run_enc(input logic [2:0] p, input logic [5:0] s, input logic [7:0] pl,
                         input bit scramble, input int abort_at, input int exp_lat);
    int done_at;
    init    = 1'b1;
    pat_sel = p;
    seed    = s;
    pre_len = pl;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    init    = 1'b0;
    done_at = -1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (abort_at >= 0 && c == abort_at) begin
        init = 1'b1;
        @(posedge clk);
        #1;
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("abort_done_hold", 32'(done), 32'd0);
        return;
      end
      if (scramble && c == 10) begin
        pat_sel = 3'($urandom_range(0, 7));
        seed    = 6'($urandom);
        pre_len = 8'($urandom);
      end
      if (done) begin
        done_at = c;
        break;
      end
    end
    if (done_at < 0) begin
      check("timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_lat >= 0) check("latency", 32'(done_at), 32'(exp_lat));
    // scoreboard
    build_expected(p, s, pl);
    for (int k = 0; k < 64; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("cipher[%0d]", 64 + k), 32'(dut.u_mem.mem[64 + k]), 32'(e));
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 32'(done), 32'd1);
  endtask

  // ---- stimulus ----
  initial begin
    logic [7:0] fixed_exp [8];
    fixed_exp = '{8'h5E, 8'h5C, 8'h58, 8'h50, 8'h40, 8'h60, 8'h61, 8'h75};
    init    = 1'b1;
    pat_sel = '0;
    seed    = '0;
    pre_len = '0;

    rand_msg();
    msg[0] = 8'h48;
    load_msg();

    // Preamble stream with known vector
    run_enc(3'd0, 6'h01, 8'd7, 1'b0, -1, 65);
    for (int i = 0; i < 8; i++)
      check($sformatf("vector[%0d]", 64 + i), 32'(dut.u_mem.mem[64 + i]), 32'(fixed_exp[i]));
    for (int i = 0; i < 64; i++) ref_img[i] = dut.u_mem.mem[64 + i];
    check("plain_kept", 32'(dut.u_mem.mem[0]), 32'h48);

    // Zero seed behaves like seed 1
    run_enc(3'd0, 6'h00, 8'd7, 1'b0, -1, 65);
    for (int i = 0; i < 64; i += 9)
      check($sformatf("zero_seed[%0d]", i), 32'(dut.u_mem.mem[64 + i]), 32'(ref_img[i]));

    // Pattern index 7 maps to 0
    run_enc(3'd7, 6'h01, 8'd7, 1'b0, -1, 65);
    for (int i = 0; i < 64; i += 9)
      check($sformatf("pat7[%0d]", i), 32'(dut.u_mem.mem[64 + i]), 32'(ref_img[i]));

    // Clamping low and high
    run_enc(3'd0, 6'h01, 8'd3, 1'b0, -1, 65);
    check("clamp_lo_first_msg", 32'(dut.u_mem.mem[71] ^ {2'b00, key_at(3'd0, 6'h01, 7)}), 32'h48);
    run_enc(3'd2, 6'h05, 8'd200, 1'b0, -1, 65);
    check("clamp_hi_pad11", 32'(dut.u_mem.mem[75] ^ {2'b00, key_at(3'd2, 6'h05, 11)}), 32'h5F);

    // Reset mid-run, then rerun with a new seed
    run_enc(3'd3, 6'h15, 8'd9, 1'b0, 30, -1);
    run_enc(3'd3, 6'h2A, 8'd9, 1'b0, -1, 65);

    // Round trip per pattern with random setup and input changes during RUN
    for (int p = 0; p < 6; p++) begin
      logic [5:0] s;
      logic [7:0] pl;
      int         plc;
      s  = 6'($urandom);
      pl = 8'($urandom_range(0, 20));
      rand_msg();
      load_msg();
      run_enc(3'(p), s, pl, 1'b1, -1, 65);
      plc = clamp_len(pl);
      for (int k = plc; k < 64; k += 7)
        check($sformatf("round_trip_p%0d[%0d]", p, k - plc),
              32'(dut.u_mem.mem[64 + k] ^ {2'b00, key_at(3'(p), s, k)}), 32'(msg[k - plc]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
